// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control types: FSM encodings, register-index width and x0 index.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } pipe_state_e;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage read of the register that the load currently in EX will write.
module load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  output logic                 hit
);

  assign hit = ex_memread && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use stalls, branch flushes, dmem waits.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int FLUSH_EXTRA = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_access,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_write,
  output logic                 idex_flush,
  output logic                 exmem_write,
  output logic                 memwb_flush,
  output logic                 mem_timeout,
  output logic                 busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt_total,
  output logic [31:0]          wait_cnt_total
`endif
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(TIMEOUT);
  localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_EXTRA);

  pipe_state_e       state_q, state_d, ret_q, ret_d, eff_state;
  logic [3:0]        flush_cnt_q, flush_cnt_d, save_cnt_q, save_cnt_d, eff_cnt;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_d;
  logic              lu_hit, freeze_req, in_wait, timeout_hit, freeze;

  load_use_detect u_lud (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .hit        (lu_hit)
  );

  assign freeze_req  = mem_access && !dmem_ready;
  assign in_wait     = (state_q == MEMWAIT);
  assign timeout_hit = in_wait && freeze_req && (TIMEOUT != 0) && (wait_cnt_q == WAIT_LIM);
  assign freeze      = freeze_req && !timeout_hit;

  // MEMWAIT is a transparent pause: the release cycle behaves like the state it interrupted.
  assign eff_state = in_wait ? (timeout_hit ? RUN : ret_q) : state_q;
  assign eff_cnt   = in_wait ? save_cnt_q : flush_cnt_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    flush_cnt_d   = flush_cnt_q;
    save_cnt_d    = save_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q_or();
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    exmem_write   = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    memwb_flush   = 1'b0;

    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
      state_d     = MEMWAIT;
      if (!in_wait) begin
        ret_d      = state_q;
        save_cnt_d = flush_cnt_q;
        wait_cnt_d = WAIT_W'(1);
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end else begin
      state_d     = RUN;
      flush_cnt_d = eff_cnt;
      memwb_flush = timeout_hit;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (FLUSH_EXTRA > 0) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end else if (eff_state == FLUSH) begin
        ifid_flush  = 1'b1;
        state_d     = (eff_cnt > 4'd1) ? FLUSH : RUN;
        flush_cnt_d = (eff_cnt != 4'd0) ? eff_cnt - 4'd1 : 4'd0;
      end else if (lu_hit) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  function automatic logic mem_timeout_q_or();
    return mem_timeout || timeout_hit;
  endfunction

  assign busy = rst_n && (state_q != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      flush_cnt_q <= '0;
      save_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      save_cnt_q  <= save_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_timeout <= mem_timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic lu_stall, br_event;

  assign br_event = !freeze && ex_branch_taken;
  assign lu_stall = !freeze && !ex_branch_taken && (eff_state == RUN) && lu_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt       <= '0;
      flush_cnt_total <= '0;
      wait_cnt_total  <= '0;
    end else begin
      if (lu_stall) stall_cnt       <= sat_inc32(stall_cnt);
      if (br_event) flush_cnt_total <= sat_inc32(flush_cnt_total);
      if (in_wait)  wait_cnt_total  <= sat_inc32(wait_cnt_total);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (FLUSH_EXTRA=2, TIMEOUT=4): directed cases plus random traffic vs a cycle model.
module tb_pipeline_hazard_ctrl;

  localparam int FE = 2;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mem_access, dmem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
  logic       memwb_flush, mem_timeout, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt_total, wait_cnt_total;
`endif

  int total = 0;
  int bad = 0;

  pipeline_hazard_ctrl #(.FLUSH_EXTRA(FE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .memwb_flush(memwb_flush), .mem_timeout(mem_timeout), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt_total(flush_cnt_total), .wait_cnt_total(wait_cnt_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0;
    ex_branch_taken = 0; mem_access = 0; dmem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  // Model state: remaining extra bubbles, whether a dmem wait is pending and how long.
  int bubbles, waited;
  bit in_wait, timed_out;
  int unsigned m_stall, m_flush, m_wait;

  always @(negedge clk) begin
    if (!rst_n) begin
      bubbles = 0; waited = 0; in_wait = 0; timed_out = 0;
      m_stall = 0; m_flush = 0; m_wait = 0;
      chk("rst_pc_write", pc_write, 0);
      chk("rst_exmem_write", exmem_write, 0);
      chk("rst_ifid_flush", ifid_flush, 1);
      chk("rst_idex_flush", idex_flush, 1);
      chk("rst_memwb_flush", memwb_flush, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mem_timeout", mem_timeout, 0);
    end else begin
      bit frozen, to, lu;
      bit e_pc, e_ifw, e_ifl, e_idw, e_idl, e_exw, e_mwf;
      frozen = mem_access && !dmem_ready && !(in_wait && waited == TO);
      to = in_wait && mem_access && !dmem_ready && !frozen;
      lu = ex_memread && ex_rd != 0 &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
      e_pc = 1; e_ifw = 1; e_idw = 1; e_exw = 1; e_ifl = 0; e_idl = 0; e_mwf = 0;
      chk("m_busy", busy, (in_wait || bubbles > 0));
      chk("m_mem_timeout", mem_timeout, timed_out);
`ifdef HAZARD_PERF_CNT_EN
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_flush_cnt_total", flush_cnt_total, m_flush);
      chk("m_wait_cnt_total", wait_cnt_total, m_wait);
`endif
      if (in_wait) m_wait++;
      if (frozen) begin
        e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_mwf = 1;
        waited = in_wait ? waited + 1 : 1;
        in_wait = 1;
      end else begin
        if (to) begin timed_out = 1; bubbles = 0; e_mwf = 1; end
        in_wait = 0;
        if (ex_branch_taken) begin
          e_ifl = 1; e_idl = 1; bubbles = FE; m_flush++;
        end else if (bubbles > 0) begin
          e_ifl = 1; bubbles--;
        end else if (lu) begin
          e_pc = 0; e_ifw = 0; e_idl = 1; m_stall++;
        end
      end
      chk("m_pc_write", pc_write, e_pc);
      chk("m_ifid_write", ifid_write, e_ifw);
      chk("m_ifid_flush", ifid_flush, e_ifl);
      chk("m_idex_write", idex_write, e_idw);
      chk("m_idex_flush", idex_flush, e_idl);
      chk("m_exmem_write", exmem_write, e_exw);
      chk("m_memwb_flush", memwb_flush, e_mwf);
    end
  end

  initial begin
    clear_in();
    #3;
    chk("reset_pc_write", pc_write, 0);
    chk("reset_ifid_flush", ifid_flush, 1);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    chk("idle_pc_write", pc_write, 1);

    tick(); ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    @(negedge clk);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_busy", busy, 0);
    tick(); @(negedge clk);
    chk("lu_after_pc_write", pc_write, 1);
    tick(); ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
    @(negedge clk);
    chk("lu_x0_pc_write", pc_write, 1);
    chk("lu_x0_idex_flush", idex_flush, 0);

    tick(); ex_branch_taken = 1;
    @(negedge clk);
    chk("br0_ifid_flush", ifid_flush, 1);
    chk("br0_idex_flush", idex_flush, 1);
    chk("br0_pc_write", pc_write, 1);
    for (int i = 0; i < FE; i++) begin
      tick(); @(negedge clk);
      chk("br_extra_ifid_flush", ifid_flush, 1);
      chk("br_extra_idex_flush", idex_flush, 0);
      chk("br_extra_busy", busy, 1);
    end
    tick(); @(negedge clk);
    chk("br_done_ifid_flush", ifid_flush, 0);
    chk("br_done_busy", busy, 0);

    for (int i = 0; i < 3; i++) begin
      tick(); mem_access = 1;
      @(negedge clk);
      chk("wait_exmem_write", exmem_write, 0);
      chk("wait_memwb_flush", memwb_flush, 1);
    end
    tick(); mem_access = 1; dmem_ready = 1;
    @(negedge clk);
    chk("ready_exmem_write", exmem_write, 1);
    chk("ready_pc_write", pc_write, 1);
    chk("ready_memwb_flush", memwb_flush, 0);

    for (int i = 0; i < TO; i++) begin
      tick(); mem_access = 1;
      @(negedge clk);
      chk("to_wait_exmem_write", exmem_write, 0);
    end
    tick(); mem_access = 1;
    @(negedge clk);
    chk("to_release_exmem_write", exmem_write, 1);
    chk("to_release_memwb_flush", memwb_flush, 1);
    chk("to_release_flag_pending", mem_timeout, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("to_sticky", mem_timeout, 1);
    end

    for (int i = 0; i < 2; i++) begin
      tick(); ex_branch_taken = 1; mem_access = 1;
      @(negedge clk);
      chk("simul_frozen_pc_write", pc_write, 0);
      chk("simul_frozen_ifid_flush", ifid_flush, 0);
    end
    tick(); ex_branch_taken = 1; mem_access = 1; dmem_ready = 1;
    @(negedge clk);
    chk("simul_release_ifid_flush", ifid_flush, 1);
    chk("simul_release_idex_flush", idex_flush, 1);
    for (int i = 0; i < 3; i++) tick();
    ex_branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_br_pc_write", pc_write, 1);
    chk("lu_br_ifid_write", ifid_write, 1);
    chk("lu_br_idex_flush", idex_flush, 1);
    for (int i = 0; i < 3; i++) tick();

    ex_branch_taken = 1;
    tick(); mem_access = 1;
    tick(); mem_access = 1;
    #3; rst_n = 0;
    #1;
    chk("midrst_pc_write", pc_write, 0);
    chk("midrst_ifid_flush", ifid_flush, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_timeout", mem_timeout, 0);
    @(posedge clk); #1; clear_in(); rst_n = 1;
    @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_pc_write", pc_write, 1);

    for (int n = 0; n < 4000; n++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0;
        tick();
        rst_n = 1;
      end
      mem_access      = ($urandom_range(0, 9) < 3);
      dmem_ready      = ($urandom_range(0, 9) < 4);
      ex_branch_taken = ($urandom_range(0, 99) < 12);
      ex_memread      = ($urandom_range(0, 9) < 5);
      ex_rd           = 5'($urandom_range(0, 3));
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
    end
    tick();
    @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
